// File: rtl/data_mem_resp_if.sv
// Request/response bus between the core M-stage (master) and the
// wait-stated data memory (slave).
interface data_mem_resp_if;
    logic        Req;
    logic        WE;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic        Ready;
    logic        Ack;
    logic [31:0] RData;
    logic        Err;

    modport master (output Req, WE, Addr, WData, input Ready, Ack, RData, Err);
    modport slave  (input Req, WE, Addr, WData, output Ready, Ack, RData, Err);
endinterface

// File: rtl/data_mem_resp.sv
// Word-addressed data RAM with programmable wait states and a tohost
// mailbox that records the first test-result store.
module data_mem_resp #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned TOHOST_ADDR = 100,
    parameter int unsigned PASS_VALUE  = 25
) (
    input  logic                 CLK,
    input  logic                 RST,
    data_mem_resp_if.slave       bus,
    output logic                 Done,
    output logic                 Pass,
    output logic [15:0]          StoreCount
);
    localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, stateNext;
    logic [3:0]  cnt, cntNext;
    logic        accept, enterResp, leaveResp;

    logic        weLat;
    logic [31:0] addrLat;
    logic [31:0] wDataLat;
    logic [31:0] mem [DEPTH];

    logic        reqWe;
    logic [31:0] reqAddr;
    logic        isTohost, accErr;
    logic [IDXW-1:0] idx;
    logic [31:0] rDataReg;
    logic        errReg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        accept    = 1'b0;
        enterResp = 1'b0;
        leaveResp = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Req) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        stateNext = RESP;
                        enterResp = 1'b1;
                    end else begin
                        stateNext = WAIT;
                        cntNext   = 4'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                cntNext = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    stateNext = RESP;
                    enterResp = 1'b1;
                end
            end
            RESP: begin
                stateNext = IDLE;
                leaveResp = 1'b1;
            end
            default: stateNext = IDLE;
        endcase
    end

    // With zero wait states the RESP entry coincides with the accept edge,
    // so decode straight from the bus while idle and from the latches after.
    assign reqWe    = (state == IDLE) ? bus.WE   : weLat;
    assign reqAddr  = (state == IDLE) ? bus.Addr : addrLat;
    assign isTohost = (reqAddr == 32'(TOHOST_ADDR));
    assign accErr   = (reqAddr[1:0] != 2'b00) ||
                      (!isTohost && (reqAddr[31:2] >= 30'(DEPTH)));
    assign idx      = reqAddr[IDXW+1:2];

    always_ff @(posedge CLK) begin
        if (RST) begin
            rDataReg   <= '0;
            errReg     <= 1'b0;
            Done       <= 1'b0;
            Pass       <= 1'b0;
            StoreCount <= '0;
        end else begin
            if (accept) begin
                weLat    <= bus.WE;
                addrLat  <= bus.Addr;
                wDataLat <= bus.WData;
            end
            if (enterResp) begin
                errReg <= accErr;
                if (accErr)
                    rDataReg <= '0;
                else if (!reqWe)
                    rDataReg <= isTohost ? {30'b0, Pass, Done} : mem[idx];
            end
            if (leaveResp) begin
                errReg <= 1'b0;
                if (weLat && !accErr) begin
                    if (isTohost) begin
                        if (!Done) begin
                            Done <= 1'b1;
                            Pass <= (wDataLat == 32'(PASS_VALUE));
                            if (StoreCount != '1)
                                StoreCount <= StoreCount + 16'd1;
                        end
                    end else if (StoreCount != '1) begin
                        StoreCount <= StoreCount + 16'd1;
                    end
                end
            end
        end
    end

    // RAM has no reset; a reset at the commit edge still blocks the write.
    always_ff @(posedge CLK) begin
        if (!RST && leaveResp && weLat && !accErr && !isTohost)
            mem[idx] <= wDataLat;
    end

    assign bus.Ready = (state == IDLE);
    assign bus.Ack   = (state == RESP);
    assign bus.RData = rDataReg;
    assign bus.Err   = errReg;
endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DEPTH, default 64, SHALL set the RAM size in 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, SHALL set the wait states between request accept and response (range 0..15).
REQ-003 Parameter TOHOST_ADDR, default 100, SHALL set the byte address of the test-result mailbox.
REQ-004 Parameter PASS_VALUE, default 25, SHALL set the mailbox store value that signals pass.
REQ-005 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 RST  input  1  SHALL be a synchronous, active-high reset.
REQ-007 Req  input  1  SHALL be the request valid from the core M-stage, held high until Ack.
REQ-008 WE  input  1  SHALL select store (1) or load (0).
REQ-009 Addr  input  32  SHALL be the byte address.
REQ-010 WData  input  32  SHALL be the store data.
REQ-011 Ready  output  1  SHALL be high only in IDLE (request can be accepted).
REQ-012 Ack  output  1  SHALL be a one-cycle completion pulse.
REQ-013 RData  output  32  SHALL be the registered load data, valid while Ack is high.
REQ-014 Err  output  1  SHALL flag a failed access, valid while Ack is high.
REQ-015 Done  output  1  SHALL be a sticky flag: mailbox written.
REQ-016 Pass  output  1  SHALL be sticky: the first mailbox store equalled PASS_VALUE.
REQ-017 StoreCount  output  16  SHALL count successful stores.

Function
REQ-018 FSM states SHALL be IDLE, WAIT and RESP.
REQ-019 IDLE with Req=1 SHALL latch WE/Addr/WData at that edge (accept edge k); later input changes SHALL be ignored until Ack.
REQ-020 On accept, the FSM SHALL go to WAIT with counter=WAIT_CYCLES, or directly to RESP if WAIT_CYCLES=0.
REQ-021 WAIT SHALL decrement the counter each edge and go to RESP on the edge where the counter equals 1, so WAIT lasts exactly WAIT_CYCLES cycles.
REQ-022 RESP SHALL last exactly one cycle, assert Ack, and return to IDLE; Ack SHALL go high after edge k+WAIT_CYCLES.
REQ-023 Back-to-back: the next request SHALL be accepted no earlier than edge k+WAIT_CYCLES+2.
REQ-024 Err SHALL be set if Addr[1:0]!=0, or if Addr!=TOHOST_ADDR and Addr[31:2]>=DEPTH; an Err access SHALL neither write nor count, and SHALL give RData=0.
REQ-025 Load: RData SHALL be loaded from RAM[Addr[31:2]] on the edge entering RESP, and held until the next Ack.
REQ-026 Store: the RAM write SHALL commit on the edge leaving RESP, so any later accepted load sees it.
REQ-027 Address TOHOST_ADDR SHALL override the RAM mapping, and RAM SHALL never be written at that address.
REQ-028 The first mailbox store SHALL set Done=1 and Pass=(WData==PASS_VALUE) and increment StoreCount.
REQ-029 Later mailbox stores SHALL be acked without Err, and SHALL leave Done, Pass and StoreCount unchanged.
REQ-030 A mailbox load SHALL return {30'b0, Pass, Done}.
REQ-031 StoreCount SHALL saturate at 0xFFFF.

Reset
REQ-032 With RST=1 at an edge, the FSM SHALL go to IDLE and the counter to 0; Ack=0, Err=0, RData=0, Done=0, Pass=0, StoreCount=0; Ready SHALL be 1 after that edge.
REQ-033 Reset mid-transaction (WAIT or RESP) SHALL discard the pending access: no RAM write, no Ack, no count.
REQ-034 RAM contents SHALL be unaffected by reset.
REQ-035 RST SHALL take priority over Req at the same edge.

Verification
REQ-036 Store 0xDEADBEEF to 0x60, then load 0x60 (WAIT_CYCLES=2) -> each Ack high after edge k+2; RData=0xDEADBEEF; StoreCount=1.
REQ-037 Store 25 to address 100, then store 7 to 100 -> Done=1, Pass=1 after the first; both acked, Err=0; StoreCount=1; RAM word 25 unchanged; loading 100 returns 0x3.
REQ-038 Store 24 to address 100 -> Done=1, Pass=0; a following store of 25 to 100 leaves Pass=0.
REQ-039 Store to 0x62, then load 0x100 (DEPTH=64) -> Ack with Err=1, RData=0, no RAM change, StoreCount unchanged.
REQ-040 RST pulsed during WAIT of a store of 0x1234 to 0x10 -> no Ack; word 4 keeps its old value; Ready=1 the next cycle; StoreCount=0.
REQ-041 WAIT_CYCLES=0 instance, load accepted at edge k -> Ack high after edge k; a second request is accepted at edge k+2.
